// File: rtl/cpu_i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: engine op codes, completion
// error codes, FSM state encoding and the device-address retry limit.
package cpu_i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } e_op;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_DEV  = 2'd1,
    ERR_REG  = 2'd2,
    ERR_DATA = 2'd3
  } e_err;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_REG,
    S_WDATA,
    S_RSTART,
    S_DEV_R,
    S_RDATA,
    S_STOP,
    S_DONE
  } e_state;

  // Extra attempts after a device-address NACK when retries are enabled.
  localparam int RETRY_MAX = 3;

  // States that drive one primitive command toward the byte engine.
  function automatic logic is_cmd_state(input e_state s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/cpu_i2c_seq.sv
// I2C register-access sequencer. Turns one request (device, register, 1..MAX_LEN
// bytes, read or write) into START/WRITE/READ/STOP primitives for the byte engine,
// one outstanding command at a time, and reports completion with an error code.
// Optional feature: define CPU_I2C_SEQ_RETRY_EN to retry device-address NACKs
// (STOP, then restart) up to RETRY_MAX times before reporting a device error.
module cpu_i2c_seq
  import cpu_i2c_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_read,
  input  logic [6:0]             req_dev,
  input  logic [7:0]             req_reg,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [MAX_LEN*8-1:0]   req_wdata,
  output logic                   done,
  output logic [1:0]             error,
  output logic [MAX_LEN*8-1:0]   rd_data,
  output logic                   busy,
  output logic                   eng_cmd_valid,
  input  logic                   eng_cmd_ready,
  output logic [1:0]             eng_cmd_op,
  output logic [7:0]             eng_tx_data,
  output logic                   eng_mack,
  input  logic                   eng_rsp_valid,
  input  logic [7:0]             eng_rsp_data,
  input  logic                   eng_rsp_ack
);

  e_state               state_reg, state_next;
  logic                 issued_reg, issued_next;      // command handed off, awaiting response
  logic [LEN_W-1:0]     idx_reg, idx_next;
  e_err                 err_reg, err_next;
  logic [MAX_LEN*8-1:0] rd_data_reg, rd_data_next;
  logic [1:0]           retry_cnt_reg, retry_cnt_next;
  logic                 retry_pend_reg, retry_pend_next; // STOP in progress leads back to START
  logic                 run_reg;                      // keeps req_ready low while in reset

  // Request fields captured at acceptance
  logic                 read_reg;
  logic [6:0]           dev_reg;
  logic [7:0]           reg_addr_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [MAX_LEN*8-1:0] wdata_reg;

  logic                 accept;
  logic                 rsp_take;
  logic                 last_byte;
  logic [7:0]           wbyte;

  assign req_ready = (state_reg == S_IDLE) && run_reg;
  assign accept    = req_valid && req_ready;
  // A response only counts once the command has been handed off; one arriving
  // in the handshake cycle itself is ignored.
  assign rsp_take  = issued_reg && eng_rsp_valid;
  assign last_byte = (idx_reg == len_reg);
  assign wbyte     = wdata_reg[{idx_reg, 3'b000} +: 8];

  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign error   = err_reg;
  assign rd_data = rd_data_reg;

  // State and datapath registers, request capture at acceptance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      issued_reg     <= 1'b0;
      idx_reg        <= '0;
      err_reg        <= ERR_OK;
      rd_data_reg    <= '0;
      retry_cnt_reg  <= 2'd0;
      retry_pend_reg <= 1'b0;
      run_reg        <= 1'b0;
      read_reg       <= 1'b0;
      dev_reg        <= '0;
      reg_addr_reg   <= '0;
      len_reg        <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      issued_reg     <= issued_next;
      idx_reg        <= idx_next;
      err_reg        <= err_next;
      rd_data_reg    <= rd_data_next;
      retry_cnt_reg  <= retry_cnt_next;
      retry_pend_reg <= retry_pend_next;
      run_reg        <= 1'b1;
      if (accept) begin
        read_reg     <= req_read;
        dev_reg      <= req_dev;
        reg_addr_reg <= req_reg;
        len_reg      <= req_len;
        wdata_reg    <= req_wdata;
      end
    end
  end

  // Next-state sequencing and engine command outputs
  always_comb begin
    state_next      = state_reg;
    issued_next     = issued_reg;
    idx_next        = idx_reg;
    err_next        = err_reg;
    rd_data_next    = rd_data_reg;
    retry_cnt_next  = retry_cnt_reg;
    retry_pend_next = retry_pend_reg;
    eng_cmd_valid   = is_cmd_state(state_reg) && !issued_reg;
    eng_cmd_op      = OP_START;
    eng_tx_data     = 8'h00;
    eng_mack        = 1'b0;

    case (state_reg)
      S_START, S_RSTART: eng_cmd_op = OP_START;
      S_STOP:            eng_cmd_op = OP_STOP;
      S_DEV_W: begin
        eng_cmd_op  = OP_WRITE;
        eng_tx_data = {dev_reg, 1'b0};
      end
      S_DEV_R: begin
        eng_cmd_op  = OP_WRITE;
        eng_tx_data = {dev_reg, 1'b1};
      end
      S_REG: begin
        eng_cmd_op  = OP_WRITE;
        eng_tx_data = reg_addr_reg;
      end
      S_WDATA: begin
        eng_cmd_op  = OP_WRITE;
        eng_tx_data = wbyte;
      end
      S_RDATA: begin
        eng_cmd_op = OP_READ;
        eng_mack   = !last_byte;
      end
      default: ;
    endcase

    if (eng_cmd_valid && eng_cmd_ready) begin
      issued_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next      = S_START;
          issued_next     = 1'b0;
          idx_next        = '0;
          err_next        = ERR_OK;
          retry_cnt_next  = 2'd0;
          retry_pend_next = 1'b0;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: begin
        if (rsp_take) begin
          issued_next = 1'b0;
          case (state_reg)
            S_START:  state_next = S_DEV_W;
            S_RSTART: state_next = S_DEV_R;
            S_DEV_W: begin
              if (eng_rsp_ack) begin
                state_next = S_REG;
              end else begin
`ifdef CPU_I2C_SEQ_RETRY_EN
                if (retry_cnt_reg < 2'(RETRY_MAX)) begin
                  retry_cnt_next  = retry_cnt_reg + 2'd1;
                  retry_pend_next = 1'b1;
                end else begin
                  err_next = ERR_DEV;
                end
`else
                err_next = ERR_DEV;
`endif
                state_next = S_STOP;
              end
            end
            S_REG: begin
              if (eng_rsp_ack) begin
                state_next = read_reg ? S_RSTART : S_WDATA;
              end else begin
                err_next   = ERR_REG;
                state_next = S_STOP;
              end
            end
            S_WDATA: begin
              if (!eng_rsp_ack) begin
                err_next   = ERR_DATA;
                state_next = S_STOP;
              end else if (last_byte) begin
                state_next = S_STOP;
              end else begin
                idx_next = idx_reg + 1'b1;
              end
            end
            S_DEV_R: begin
              if (eng_rsp_ack) begin
                state_next = S_RDATA;
              end else begin
                err_next   = ERR_DEV;
                state_next = S_STOP;
              end
            end
            S_RDATA: begin
              rd_data_next[{idx_reg, 3'b000} +: 8] = eng_rsp_data;
              if (last_byte) begin
                state_next = S_STOP;
              end else begin
                idx_next = idx_reg + 1'b1;
              end
            end
            S_STOP: begin
              if (retry_pend_reg) begin
                retry_pend_next = 1'b0;
                state_next      = S_START;
              end else begin
                state_next = S_DONE;
              end
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_i2c_seq.sv
// Directed bench for cpu_i2c_seq: plays the byte engine by hand, checking each
// primitive command and the completion status against hand-computed values.
module tb_cpu_i2c_seq;
  import cpu_i2c_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic [6:0]  req_dev = '0;
  logic [7:0]  req_reg = '0;
  logic [2:0]  req_len = '0;
  logic [63:0] req_wdata = '0;
  logic        done;
  logic [1:0]  error;
  logic [63:0] rd_data;
  logic        busy;
  logic        eng_cmd_valid;
  logic        eng_cmd_ready = 1'b0;
  logic [1:0]  eng_cmd_op;
  logic [7:0]  eng_tx_data;
  logic        eng_mack;
  logic        eng_rsp_valid = 1'b0;
  logic [7:0]  eng_rsp_data = '0;
  logic        eng_rsp_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  int txn = 0;

  cpu_i2c_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
    .done(done), .error(error), .rd_data(rd_data), .busy(busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_cmd_op(eng_cmd_op), .eng_tx_data(eng_tx_data), .eng_mack(eng_mack),
    .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data), .eng_rsp_ack(eng_rsp_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request once ready, then confirm acceptance and first command.
  task automatic start(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [2:0] len, input logic [63:0] wd);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_read = rd; req_dev = dev; req_reg = rg;
    req_len = len; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("first_cmd_valid", eng_cmd_valid, 1'b1);
  endtask

  // Act as the engine for one primitive: check it, stall, accept, respond.
  task automatic eng(input string tag, input logic [1:0] op, input logic [7:0] data,
                     input logic mack, input logic ack, input logic [7:0] rdat,
                     input int stall);
    int n = 0;
    while (!eng_cmd_valid && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, eng_cmd_valid, 1'b1);
    chk({tag, "_op"}, eng_cmd_op, op);
    if (op == OP_WRITE) chk({tag, "_tx"}, eng_tx_data, data);
    if (op == OP_READ)  chk({tag, "_mack"}, eng_mack, mack);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_valid"}, eng_cmd_valid, 1'b1);
      chk({tag, "_hold_op"}, eng_cmd_op, op);
      chk({tag, "_hold_tx"}, eng_tx_data, data);
    end
    eng_cmd_ready = 1'b1;
    tick();
    eng_cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, eng_cmd_valid, 1'b0);
    eng_rsp_valid = 1'b1; eng_rsp_ack = ack; eng_rsp_data = rdat;
    tick();
    eng_rsp_valid = 1'b0; eng_rsp_ack = 1'b0; eng_rsp_data = 8'h00;
  endtask

  // Called right after the STOP response: done pulse, status, then idle.
  task automatic finish(input string tag, input logic [1:0] exp_err, input logic [63:0] exp_rd);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_rd_data"}, rd_data, exp_rd);
    chk({tag, "_ready_in_done"}, req_ready, 1'b0);
    txn++;
    $display("txn %0d %s: error=%0d rd_data=%h", txn, tag, error, rd_data);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ready_after"}, req_ready, 1'b1);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", eng_cmd_valid, 1'b0);
    chk("rst_error", error, 2'd0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_op", eng_cmd_op, OP_START);
    chk("rst_tx", eng_tx_data, 8'h00);
    chk("rst_mack", eng_mack, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_ready", req_ready, 1'b1);

    // Single-byte write, all ACK
    start(1'b0, 7'h68, 8'h07, 3'd0, 64'h5A);
    eng("w1_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("w1_dev",   OP_WRITE, 8'hD0, 1'b0, 1'b1, 8'h00, 0);
    eng("w1_reg",   OP_WRITE, 8'h07, 1'b0, 1'b1, 8'h00, 0);
    eng("w1_d0",    OP_WRITE, 8'h5A, 1'b0, 1'b1, 8'h00, 0);
    eng("w1_stop",  OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("w1", 2'd0, 64'h0);

    // Four-byte read
    start(1'b1, 7'h50, 8'h10, 3'd3, 64'h0);
    eng("r1_start",  OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r1_devw",   OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00, 0);
    eng("r1_reg",    OP_WRITE, 8'h10, 1'b0, 1'b1, 8'h00, 0);
    eng("r1_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r1_devr",   OP_WRITE, 8'hA1, 1'b0, 1'b1, 8'h00, 0);
    eng("r1_b0",     OP_READ,  8'h00, 1'b1, 1'b1, 8'h11, 0);
    eng("r1_b1",     OP_READ,  8'h00, 1'b1, 1'b1, 8'h22, 0);
    eng("r1_b2",     OP_READ,  8'h00, 1'b1, 1'b1, 8'h33, 0);
    eng("r1_b3",     OP_READ,  8'h00, 1'b0, 1'b1, 8'h44, 0);
    eng("r1_stop",   OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("r1", 2'd0, 64'h44332211);

    // Write with register NACK: STOP right after REG, rd_data untouched
    start(1'b0, 7'h68, 8'h33, 3'd2, 64'hCCBBAA);
    eng("w2_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("w2_dev",   OP_WRITE, 8'hD0, 1'b0, 1'b1, 8'h00, 0);
    eng("w2_reg",   OP_WRITE, 8'h33, 1'b0, 1'b0, 8'h00, 0);
    eng("w2_stop",  OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("w2", 2'd2, 64'h44332211);

    // Device NACK on every attempt
    start(1'b0, 7'h68, 8'h01, 3'd0, 64'h99);
`ifdef CPU_I2C_SEQ_RETRY_EN
    for (int a = 0; a < 4; a++) begin
      eng("nk_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
      eng("nk_dev",   OP_WRITE, 8'hD0, 1'b0, 1'b0, 8'h00, 0);
      eng("nk_stop",  OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    end
`else
    eng("nk_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("nk_dev",   OP_WRITE, 8'hD0, 1'b0, 1'b0, 8'h00, 0);
    eng("nk_stop",  OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
`endif
    finish("nk", 2'd1, 64'h44332211);

    // Stalled engine plus a request held while busy; data NACK on last byte
    start(1'b0, 7'h2C, 8'h01, 3'd1, 64'h2211);
    req_valid = 1'b1; req_read = 1'b1; req_dev = 7'h3B; req_reg = 8'h05;
    req_len = 3'd0; req_wdata = 64'h0;
    eng("w3_start", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 5);
    chk("w3_held_not_ready", req_ready, 1'b0);
    eng("w3_dev",   OP_WRITE, 8'h58, 1'b0, 1'b1, 8'h00, 0);
    eng("w3_reg",   OP_WRITE, 8'h01, 1'b0, 1'b1, 8'h00, 0);
    eng("w3_d0",    OP_WRITE, 8'h11, 1'b0, 1'b1, 8'h00, 5);
    eng("w3_d1",    OP_WRITE, 8'h22, 1'b0, 1'b0, 8'h00, 0);
    eng("w3_stop",  OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("w3", 2'd3, 64'h44332211);
    // Held read is accepted now that the sequencer is idle
    tick();
    req_valid = 1'b0;
    chk("held_accepted", busy, 1'b1);
    eng("r2_start",  OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r2_devw",   OP_WRITE, 8'h76, 1'b0, 1'b1, 8'h00, 0);
    eng("r2_reg",    OP_WRITE, 8'h05, 1'b0, 1'b1, 8'h00, 0);
    eng("r2_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r2_devr",   OP_WRITE, 8'h77, 1'b0, 1'b0, 8'h00, 0);
    eng("r2_stop",   OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("r2", 2'd1, 64'h44332211);

    // Reset during RDATA aborts at once, then a fresh read completes
    start(1'b1, 7'h50, 8'h20, 3'd2, 64'h0);
    eng("r3_start",  OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r3_devw",   OP_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00, 0);
    eng("r3_reg",    OP_WRITE, 8'h20, 1'b0, 1'b1, 8'h00, 0);
    eng("r3_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r3_devr",   OP_WRITE, 8'hA1, 1'b0, 1'b1, 8'h00, 0);
    eng("r3_b0",     OP_READ,  8'h00, 1'b1, 1'b1, 8'h77, 0);
    chk("r3_in_rdata", eng_cmd_op, OP_READ);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ready", req_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_valid", eng_cmd_valid, 1'b0);
    chk("mid_rst_error", error, 2'd0);
    chk("mid_rst_rd_data", rd_data, 64'h0);
    chk("mid_rst_op", eng_cmd_op, OP_START);
    chk("mid_rst_tx", eng_tx_data, 8'h00);
    chk("mid_rst_mack", eng_mack, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("mid_rst_release_ready", req_ready, 1'b1);
    start(1'b1, 7'h51, 8'h00, 3'd1, 64'h0);
    eng("r4_start",  OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r4_devw",   OP_WRITE, 8'hA2, 1'b0, 1'b1, 8'h00, 0);
    eng("r4_reg",    OP_WRITE, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r4_rstart", OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    eng("r4_devr",   OP_WRITE, 8'hA3, 1'b0, 1'b1, 8'h00, 0);
    eng("r4_b0",     OP_READ,  8'h00, 1'b1, 1'b1, 8'h9A, 0);
    eng("r4_b1",     OP_READ,  8'h00, 1'b0, 1'b1, 8'hBC, 0);
    eng("r4_stop",   OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0);
    finish("r4", 2'd0, 64'hBC9A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_i2c_seq.md
# cpu_i2c_seq

Transaction sequencer that sits directly upstream of the byte-level I2C master. It accepts one complete register access per request: device address, register index, and 1–8 data bytes, either read or write. It breaks the access into START / byte-write / byte-read / STOP primitives, issues them one at a time over a command/response handshake, collects read data, and reports completion and NACK errors. This frees CPU firmware from per-byte polling for RTC/EEPROM accesses.

## Interface
Parameters:
- MAX_LEN, 8, maximum data bytes per request; data buses are MAX_LEN*8 wide; length counter is $clog2(MAX_LEN) bits.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_read  in  1  1 = register read, 0 = register write.
- req_dev  in  7  7-bit device address.
- req_reg  in  8  register index.
- req_len  in  3  byte count minus one (0 → 1 byte, 7 → 8 bytes).
- req_wdata  in  64  write bytes; byte k is bits [8k+7:8k].
- done  out  1  one-cycle completion pulse.
- error  out  2  valid with done: 0 = OK, 1 = device NACK, 2 = register NACK, 3 = data NACK.
- rd_data  out  64  read bytes, same packing; stable from done until the next accepted request.
- busy  out  1  high whenever state ≠ IDLE.
- eng_cmd_valid  out  1  primitive command present.
- eng_cmd_ready  in  1  engine accepts the command.
- eng_cmd_op  out  2  0 = START, 1 = STOP, 2 = WRITE, 3 = READ.
- eng_tx_data  out  8  byte for WRITE.
- eng_mack  out  1  for READ: 1 = master ACKs, 0 = master NACKs.
- eng_rsp_valid  in  1  one-cycle pulse; exactly one per accepted command.
- eng_rsp_data  in  8  received byte (READ).
- eng_rsp_ack  in  1  slave ACK for WRITE (1 = ACK).

## Operation
- States:
  - IDLE
  - START
  - DEV_W
  - REG
  - WDATA
  - RSTART
  - DEV_R
  - RDATA
  - STOP
  - DONE
- Each non-IDLE/DONE state issues one command, then waits for eng_rsp_valid before transitioning.
- A request is accepted on req_valid & req_ready. All request fields are latched at acceptance, and byte index is cleared.
- Write sequence: START → DEV_W ({dev,0}) → REG → WDATA × (len+1) → STOP → DONE.
- Read sequence: START → DEV_W → REG → RSTART (START op) → DEV_R ({dev,1}) → RDATA × (len+1) → STOP → DONE.
- RDATA:
  - eng_mack = 1 for every byte except the last, which gets 0.
  - The received byte is stored at the current index.
- NACK (eng_rsp_ack = 0) on DEV_W, DEV_R, REG or WDATA:
  - Record the error code (DEV_R reports 1).
  - Skip the remaining bytes, go to STOP, then DONE.
- STOP is always issued before DONE.
- The byte index increments after each data response. The last-byte test is index == len_latched; there is no wrap.
- Write bytes not sent: rd_data is unchanged on writes.
- Reset values:
  - state = IDLE
  - req_ready = 0 during reset, then 1
  - busy, done, eng_cmd_valid = 0
  - error = 0
  - rd_data = 0
  - eng_cmd_op = START
  - eng_tx_data = 0
  - eng_mack = 0
- Reset mid-transaction aborts immediately. No STOP is issued; the next request's START re-synchronises the bus.

## Timing
- First command is valid the cycle after request acceptance.
- eng_cmd_valid, op and data are held stable until eng_cmd_ready. Valid drops the cycle after the handshake.
- At most one command is outstanding.
- The next command is valid the cycle after eng_rsp_valid.
- eng_rsp_valid arriving in the same cycle as a handshake is illegal and ignored.
- done rises the cycle after the STOP response and lasts 1 cycle. req_ready rises the following cycle.
- Minimum gap between consecutive accepted requests: done cycle + 1.
- A request held during busy is not accepted and not lost; req_valid simply waits.

## Configuration
- CPU_I2C_SEQ_RETRY_EN defined:
  - A DEV_W NACK issues STOP, then restarts from START, up to 3 retries.
  - error = 1 is reported only after the 4th consecutive NACK.
  - The retry counter clears at acceptance.
- Not defined: the first DEV_W NACK ends the request with error = 1.
- REG/data/DEV_R NACKs are never retried in either configuration.

## Structure
- Shared package cpu_i2c_seq_pkg holds:
  - e_op (eng_cmd_op encoding)
  - e_err (error codes)
  - e_state
  - constant RETRY_MAX = 3
- Single module; no sub-module needed. The data buffer is a flat MAX_LEN×8 register indexed by the byte counter.

## Test plan
- Write dev 0x68, reg 0x07, len 0, data 0x5A, all ACK → ops START, W 0xD0, W 0x07, W 0x5A, STOP; done, error 0.
- Read dev 0x50, reg 0x10, len 3, engine returns 11,22,33,44 → ops START, W A0, W 10, START, W A1, R(mack1)×3, R(mack0), STOP; rd_data = 0x44332211.
- Write with NACK on REG → STOP issued immediately after REG; no data writes; error 2.
- Device NACK on every attempt:
  - Macro off → 1 START, error 1.
  - Macro on → 4 START/STOP pairs, error 1.
- eng_cmd_ready held low 5 cycles → op/data stable, valid held; req_valid asserted while busy not accepted until after done.
- reset_n low during RDATA → next cycle all outputs at reset values; a new read then completes normally.
